// File: rtl/regfile_param.sv
// regfile_param: parametrised register file with NREAD combinational read ports,
// two write ports (B wins on collision), optional write-to-read bypass, a per-register
// busy scoreboard and a registered write-collision flag. Reset is synchronous, active-low.
module regfile_param #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned DEPTH    = 32,
    parameter int unsigned NREAD    = 2,
    parameter bit          ZERO_REG = 1'b1,
    parameter bit          BYPASS   = 1'b0,
    localparam int unsigned AW      = ($clog2(DEPTH) > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                   Clk,
    input  logic                   ResetN,
    input  logic [NREAD*AW-1:0]    ReadRegister,
    output logic [NREAD*WIDTH-1:0] ReadData,
    output logic [NREAD-1:0]       ReadBusy,
    input  logic [AW-1:0]          WriteRegisterA,
    input  logic [WIDTH-1:0]       WriteDataA,
    input  logic                   RegWriteA,
    input  logic [AW-1:0]          WriteRegisterB,
    input  logic [WIDTH-1:0]       WriteDataB,
    input  logic                   RegWriteB,
    input  logic                   Reserve,
    input  logic [AW-1:0]          ReserveRegister,
    output logic                   WriteConflict
);

    // One extra bit so DEPTH == 2**AW is representable.
    localparam logic [AW:0] LP_DEPTH = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [DEPTH-1:0] r_busy;
    logic             r_conflict;

    logic w_we_a;
    logic w_we_b;
    logic w_res;

    // An address is writable when in range and not the hardwired zero register.
    function automatic logic addr_ok(input logic [AW-1:0] a);
        return ({1'b0, a} < LP_DEPTH) && !(ZERO_REG && (a == '0));
    endfunction

    // Qualify write and reserve requests against the address range and register 0.
    always_comb begin
        w_we_a = RegWriteA && addr_ok(WriteRegisterA);
        w_we_b = RegWriteB && addr_ok(WriteRegisterB);
        w_res  = Reserve && addr_ok(ReserveRegister);
    end

    // Register storage; B is assigned last so it wins a same-address collision.
    always_ff @(posedge Clk) begin
        if (!ResetN) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_we_a) begin
                r_mem[WriteRegisterA] <= WriteDataA;
            end
            if (w_we_b) begin
                r_mem[WriteRegisterB] <= WriteDataB;
            end
        end
    end

    // Busy scoreboard; a reservation is the newer producer, so it overrides a write clear.
    always_ff @(posedge Clk) begin
        if (!ResetN) begin
            r_busy <= '0;
        end else begin
            if (w_we_a) begin
                r_busy[WriteRegisterA] <= 1'b0;
            end
            if (w_we_b) begin
                r_busy[WriteRegisterB] <= 1'b0;
            end
            if (w_res) begin
                r_busy[ReserveRegister] <= 1'b1;
            end
        end
    end

    // Collision flag: both ports committed to the same register on this edge.
    always_ff @(posedge Clk) begin
        if (!ResetN) begin
            r_conflict <= 1'b0;
        end else begin
            r_conflict <= w_we_a && w_we_b && (WriteRegisterA == WriteRegisterB);
        end
    end

    assign WriteConflict = r_conflict;

    // Combinational read ports with optional forwarding of this cycle's write data.
    always_comb begin
        logic [AW-1:0] w_addr;
        ReadData = '0;
        ReadBusy = '0;
        w_addr   = '0;
        for (int p = 0; p < int'(NREAD); p++) begin
            w_addr = ReadRegister[p*AW +: AW];
            if (addr_ok(w_addr)) begin
                ReadData[p*WIDTH +: WIDTH] = r_mem[w_addr];
                ReadBusy[p]                = r_busy[w_addr];
            end
            if (BYPASS) begin
                // Busy stays visible only if a newer reservation lands on the same edge.
                if (w_we_b && (WriteRegisterB == w_addr)) begin
                    ReadData[p*WIDTH +: WIDTH] = WriteDataB;
                    ReadBusy[p]                = w_res && (ReserveRegister == w_addr);
                end else if (w_we_a && (WriteRegisterA == w_addr)) begin
                    ReadData[p*WIDTH +: WIDTH] = WriteDataA;
                    ReadBusy[p]                = w_res && (ReserveRegister == w_addr);
                end
            end
        end
    end

endmodule

// File: doc/regfile_param.md
# regfile_param

Parametrised multi-port register file, the successor to the fixed 32×32, 2-read/1-write register file used in the single-cycle CPU datapath. It generalises width, depth and read-port count, and adds several features the previous generation lacks:
- a second write port for dual-issue/writeback;
- optional write-to-read bypass;
- a synchronous reset;
- a per-register busy scoreboard for the pipelined core's hazard logic.

## Interface
Parameters:
- WIDTH, 32: data bits per register.
- DEPTH, 32: number of registers, ≥2; AW = max(1, $clog2(DEPTH)) is a derived localparam.
- NREAD, 2: number of read ports, ≥1.
- ZERO_REG, 1: 1 = register 0 is hardwired to zero.
- BYPASS, 0: 1 = same-cycle write data is forwarded to matching reads.

Ports (one clock; reset is synchronous and active-low):
- Clk  in  1  clock, all state updates on its rising edge.
- ResetN  in  1  synchronous active-low reset.
- ReadRegister  in  NREAD*AW  read addresses; port i occupies bits [i*AW +: AW].
- ReadData  out  NREAD*WIDTH  read data; port i occupies bits [i*WIDTH +: WIDTH].
- ReadBusy  out  NREAD  busy bit of the register addressed by each read port.
- WriteRegisterA / WriteDataA / RegWriteA  in  AW / WIDTH / 1  write port A.
- WriteRegisterB / WriteDataB / RegWriteB  in  AW / WIDTH / 1  write port B; B has priority over A.
- Reserve  in  1  when high, marks ReserveRegister busy at the next edge.
- ReserveRegister  in  AW  address to reserve.
- WriteConflict  out  1  registered flag: both ports wrote the same register on the previous edge.

## Operation
- Storage: DEPTH×WIDTH flops, plus DEPTH busy bits, plus the WriteConflict flop.
- Reset (ResetN=0 at a rising edge):
  - all registers become 0, all busy bits 0, WriteConflict 0;
  - reset overrides every write, reserve and conflict event in that cycle.
- Write, valid address: port X commits WriteDataX at the edge when RegWriteX=1 and WriteRegisterX<DEPTH.
- Write, invalid address: addresses ≥DEPTH are ignored; no write and no busy change.
- Write collision: A and B enabled to the same valid address → B's data is stored. WriteConflict=1 for the following cycle, except when the address is 0 with ZERO_REG=1.
- Register 0 with ZERO_REG=1:
  - always reads 0 and ReadBusy=0;
  - writes and reserves to it are discarded;
  - it is never bypassed.
- Reads are combinational from the address:
  - address ≥DEPTH reads 0 with busy 0;
  - otherwise the read returns the stored value.
- Bypass, BYPASS=1:
  - if a read address equals an enabled valid write address this cycle, ReadData shows that write's data combinationally;
  - B takes precedence when both ports match;
  - ReadBusy shows 0 when a write to that address is present, unless Reserve targets the same address.
- Bypass, BYPASS=0: the read shows the old value until the edge.
- Busy scoreboard:
  - a committed write from either port clears the register's busy bit;
  - Reserve sets it;
  - Reserve and a write to the same register on the same edge → the write commits and busy ends at 1 (the reservation represents a newer producer).
- Reads during reset cycle: ReadData reflects pre-reset contents until the reset edge. With BYPASS=1, a bypass still shows write data, but that data is not committed.

## Timing
- Write latency: data is visible on reads 1 cycle after the edge (BYPASS=0), or in the same cycle (BYPASS=1).
- Busy latency: set/clear is visible 1 cycle after the edge, except for the bypass masking described under Operation.
- WriteConflict: asserted for exactly the cycle following the colliding edge. Back-to-back collisions keep it high.
- Outputs after reset: ReadData=0 for all ports, ReadBusy=0, WriteConflict=0.
- Timing paths: no combinational path from any input to WriteConflict. The read path is address → mux, plus the bypass compare when BYPASS=1.

## Test plan
- Reset then read every address on all ports → all ReadData=0, ReadBusy=0. Write 42 to r2 via A, read r2 on ports 0 and 1 next cycle → 42 on both.
- Enable A=r5←15 and B=r5←99 on the same edge → r5 reads 99, WriteConflict=1 for exactly one cycle, then 0. Write r0←10 with ZERO_REG=1 → reads 0, WriteConflict stays 0.
- Write r2←10, then RegWriteA=0 with WriteDataA=5 addressed to r2 → r2 still 10. Write r3←5 → r2 still 10, r3=5; each port read independently with NREAD=3.
- BYPASS=1: r7 holds 1; present A=r7←8, read r7 before the edge → ReadData=8. BYPASS=0 same stimulus → reads 1 before the edge, 8 after.
- Reserve r4 → ReadBusy=1 next cycle; write r4←3 → busy 0. Reserve+write r4 on the same edge → r4=3 and busy=1.
- Mid-run ResetN=0 for one edge while A writes r6←77 and Reserve targets r6 → r6=0, busy 0, WriteConflict 0. With DEPTH=24, a write to address 30 is ignored and a read of address 30 returns 0.
